// File: rtl/window_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_buf_pkg
// Description : Shared defaults for the 3x3 window generator.
//               The interface and the top import this package.
// Revision    : 1.0 - initial release
// ============================================================================
package window_buf_pkg;

    // Default raster geometry and element width
    localparam int c_DEF_ELEM_LEN  = 1;
    localparam int c_DEF_LINE_LEN  = 640;
    localparam int c_DEF_NUM_LINES = 480;

endpackage
`default_nettype wire

// File: rtl/window_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : window_buf_if
// Description : Pixel-in / window-out bundle of the 3x3 window generator.
//               slave = the window block, master = the pixel source/sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface window_buf_if
    import window_buf_pkg::*;
#(
    parameter int ELEM_LEN  = c_DEF_ELEM_LEN,
    parameter int LINE_LEN  = c_DEF_LINE_LEN,
    parameter int NUM_LINES = c_DEF_NUM_LINES
);
    localparam int c_XW = $clog2(LINE_LEN);
    localparam int c_YW = $clog2(NUM_LINES);

    logic                in_valid;
    logic                in_ready;
    logic                sof;
    logic [ELEM_LEN-1:0] pixel_in;

    logic                out_valid;
    logic [c_XW-1:0]     out_x;
    logic [c_YW-1:0]     out_y;
    logic [ELEM_LEN-1:0] a0, a1, a2, a3, a4, a5, a6, a7, pix;

    modport slave (
        input  in_valid, sof, pixel_in,
        output in_ready, out_valid, out_x, out_y,
               a0, a1, a2, a3, a4, a5, a6, a7, pix
    );

    modport master (
        output in_valid, sof, pixel_in,
        input  in_ready, out_valid, out_x, out_y,
               a0, a1, a2, a3, a4, a5, a6, a7, pix
    );

endinterface
`default_nettype wire

// File: rtl/window_buf_shift_line.sv
`default_nettype none
// ============================================================================
// Module      : shift_line
// Description : Enable-gated delay line of DEPTH elements. o_dout is the
//               oldest stored element. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_line #(
    parameter int ELEM_LEN = 1,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                i_en,
    input  logic [ELEM_LEN-1:0] i_din,
    output logic [ELEM_LEN-1:0] o_dout
);

    logic [ELEM_LEN-1:0] r_mem [DEPTH];

    // Shift one position per enabled cycle, newest element at index 0
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[0] <= i_din;
            for (int k = 1; k < DEPTH; k++) begin
                r_mem[k] <= r_mem[k-1];
            end
        end
    end

    assign o_dout = r_mem[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/window_buf.sv
`default_nettype none
// ============================================================================
// Module      : window_buf
// Description : 3x3 neighbourhood generator for raster-order pixel streams
//               with accept handshake, border padding and end-of-frame flush.
// Revision    : 1.0 - initial release
// ============================================================================
module window_buf
    import window_buf_pkg::*;
#(
    parameter int                  ELEM_LEN  = c_DEF_ELEM_LEN,
    parameter int                  LINE_LEN  = c_DEF_LINE_LEN,
    parameter int                  NUM_LINES = c_DEF_NUM_LINES,
    parameter logic [ELEM_LEN-1:0] PAD_VAL   = '0
) (
    input  logic        clk,
    input  logic        rst,
    window_buf_if.slave bus
);

    localparam int c_XW = $clog2(LINE_LEN);
    localparam int c_YW = $clog2(NUM_LINES);
    localparam int c_FW = $clog2(LINE_LEN + 2);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FILL  = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_FLUSH = 2'd3;

    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(LINE_LEN - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(NUM_LINES - 1);
    // Centre position whose window is produced by the last pixel of a frame
    localparam logic [c_XW-1:0] c_X_PRE  = c_XW'(LINE_LEN - 2);
    localparam logic [c_YW-1:0] c_Y_PRE  = c_YW'(NUM_LINES - 2);
    // Beat count (fill) or beat index (flush) at which the state moves on
    localparam logic [c_FW-1:0] c_CNT_END = c_FW'(LINE_LEN);

    logic [1:0]      r_state, w_state_nxt;
    logic [c_FW-1:0] r_cnt, w_cnt_nxt;
    logic [c_XW-1:0] r_cx, w_cx_nxt;    // centre of the next window to emit
    logic [c_YW-1:0] r_cy, w_cy_nxt;
    logic            r_in_ready;

    logic                w_accept;
    logic                w_adv;
    logic                w_adv_en;
    logic                w_emit;
    logic [ELEM_LEN-1:0] w_din;
    logic [ELEM_LEN-1:0] w_la_out;      // pixel one line back
    logic [ELEM_LEN-1:0] w_lb_out;      // pixel two lines back

    // Two trailing window columns, index 0 = top, 1 = middle, 2 = bottom
    logic [2:0][ELEM_LEN-1:0] r_col1, r_col2;

    logic                w_pad_t, w_pad_b, w_pad_l, w_pad_r;
    logic                r_out_valid;
    logic [c_XW-1:0]     r_out_x;
    logic [c_YW-1:0]     r_out_y;
    logic [ELEM_LEN-1:0] r_a0, r_a1, r_a2, r_a3, r_a4, r_a5, r_a6, r_a7, r_pix;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_adv_en = w_adv & ~rst;

    // State, beat counter and centre-coordinate register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cx       <= w_cx_nxt;
            r_cy       <= w_cy_nxt;
            r_in_ready <= (w_state_nxt != c_ST_FLUSH);
        end
    end

    // Next-state, advance/emit decisions and centre-coordinate stepping
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cx_nxt    = r_cx;
        w_cy_nxt    = r_cy;
        w_adv       = 1'b0;
        w_emit      = 1'b0;
        w_din       = bus.pixel_in;
        if (w_accept && bus.sof) begin
            // sof always (re)starts a frame: this beat is pixel (0,0)
            w_adv       = 1'b1;
            w_state_nxt = c_ST_FILL;
            w_cnt_nxt   = c_FW'(1);
            w_cx_nxt    = '0;
            w_cy_nxt    = '0;
        end else begin
            case (r_state)
                c_ST_FILL: begin
                    if (w_accept) begin
                        w_adv     = 1'b1;
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (r_cnt == c_CNT_END) begin
                            w_state_nxt = c_ST_RUN;
                        end
                    end
                end
                c_ST_RUN: begin
                    if (w_accept) begin
                        w_adv  = 1'b1;
                        w_emit = 1'b1;
                        if (r_cx == c_X_PRE && r_cy == c_Y_PRE) begin
                            w_state_nxt = c_ST_FLUSH;
                            w_cnt_nxt   = '0;
                        end
                    end
                end
                c_ST_FLUSH: begin
                    w_adv     = 1'b1;
                    w_emit    = 1'b1;
                    w_din     = PAD_VAL;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_CNT_END) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                default: begin
                    // IDLE: beats without sof are dropped
                end
            endcase
        end
        if (w_emit) begin
            if (r_cx == c_X_LAST) begin
                w_cx_nxt = '0;
                w_cy_nxt = (r_cy == c_Y_LAST) ? '0 : r_cy + 1'b1;
            end else begin
                w_cx_nxt = r_cx + 1'b1;
            end
        end
    end

    shift_line #(
        .ELEM_LEN (ELEM_LEN),
        .DEPTH    (LINE_LEN)
    ) u_line_a (
        .clk    (clk),
        .i_en   (w_adv_en),
        .i_din  (w_din),
        .o_dout (w_la_out)
    );

    shift_line #(
        .ELEM_LEN (ELEM_LEN),
        .DEPTH    (LINE_LEN)
    ) u_line_b (
        .clk    (clk),
        .i_en   (w_adv_en),
        .i_din  (w_la_out),
        .o_dout (w_lb_out)
    );

    // Trailing columns: the newest column is formed from the line outputs
    always_ff @(posedge clk) begin
        if (w_adv_en) begin
            r_col2 <= r_col1;
            r_col1 <= {w_din, w_la_out, w_lb_out};
        end
    end

    assign w_pad_t = (r_cy == '0);
    assign w_pad_b = (r_cy == c_Y_LAST);
    assign w_pad_l = (r_cx == '0);
    assign w_pad_r = (r_cx == c_X_LAST);

    // Registered, border-padded window for the centre at (r_cx, r_cy)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_a0        <= '0;
            r_a1        <= '0;
            r_a2        <= '0;
            r_a3        <= '0;
            r_a4        <= '0;
            r_a5        <= '0;
            r_a6        <= '0;
            r_a7        <= '0;
            r_pix       <= '0;
        end else begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_x <= r_cx;
                r_out_y <= r_cy;
                r_a0    <= (w_pad_t | w_pad_l) ? PAD_VAL : r_col2[0];
                r_a1    <= w_pad_t             ? PAD_VAL : r_col1[0];
                r_a2    <= (w_pad_t | w_pad_r) ? PAD_VAL : w_lb_out;
                r_a3    <= w_pad_r             ? PAD_VAL : w_la_out;
                r_a4    <= (w_pad_b | w_pad_r) ? PAD_VAL : w_din;
                r_a5    <= w_pad_b             ? PAD_VAL : r_col1[2];
                r_a6    <= (w_pad_b | w_pad_l) ? PAD_VAL : r_col2[2];
                r_a7    <= w_pad_l             ? PAD_VAL : r_col2[1];
                r_pix   <= r_col1[1];
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_x     = r_out_x;
    assign bus.out_y     = r_out_y;
    assign bus.a0        = r_a0;
    assign bus.a1        = r_a1;
    assign bus.a2        = r_a2;
    assign bus.a3        = r_a3;
    assign bus.a4        = r_a4;
    assign bus.a5        = r_a5;
    assign bus.a6        = r_a6;
    assign bus.a7        = r_a7;
    assign bus.pix       = r_pix;

endmodule
`default_nettype wire

// File: tb/tb_window_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_buf
// Description : Scoreboard bench for window_buf, 4x3 frames of 8-bit pixels
//               with pixel = 16*y + x and pad value 0xFF.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_buf;

    localparam int c_W = 4;
    localparam int c_H = 3;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
        logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, pix;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    bit   beat_last = 1'b0;
    win_t sb[$];

    window_buf_if #(.ELEM_LEN(8), .LINE_LEN(c_W), .NUM_LINES(c_H)) bus ();

    window_buf #(
        .ELEM_LEN  (8),
        .LINE_LEN  (c_W),
        .NUM_LINES (c_H),
        .PAD_VAL   (8'hFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Image value at (xx,yy), pad outside the frame
    function automatic logic [7:0] pv(input int xx, input int yy);
        if (xx < 0 || xx >= c_W || yy < 0 || yy >= c_H) return 8'hFF;
        return 8'(16 * yy + xx);
    endfunction

    function automatic win_t model(input int x, input int y);
        win_t w;
        w.x   = 2'(x);
        w.y   = 2'(y);
        w.a0  = pv(x - 1, y - 1);
        w.a1  = pv(x,     y - 1);
        w.a2  = pv(x + 1, y - 1);
        w.a3  = pv(x + 1, y);
        w.a4  = pv(x + 1, y + 1);
        w.a5  = pv(x,     y + 1);
        w.a6  = pv(x - 1, y + 1);
        w.a7  = pv(x - 1, y);
        w.pix = pv(x, y);
        return w;
    endfunction

    function automatic logic [7:0] px(input int i);
        return 8'(16 * (i / c_W) + (i % c_W));
    endfunction

    task automatic push_range(input int first, input int last);
        for (int i = first; i <= last; i++) sb.push_back(model(i % c_W, i / c_W));
    endtask

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.sof      = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted
    task automatic send(input logic [7:0] p, input logic s);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.pixel_in = p;
        bus.sof      = s;
        for (int g = 0; g < 100 && !done; g++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL accept_timeout: pixel %0h never accepted", p);
        end
        bus.in_valid = 1'b0;
        bus.sof      = 1'b0;
    endtask

    task automatic send_frame(input bit bubbles);
        for (int i = 0; i < c_W * c_H; i++) begin
            if (bubbles && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
            send(px(i), i == 0);
        end
    endtask

    // Called right after the last accept: count in_ready-low cycles and flush windows
    task automatic flush_check();
        int  low = 0;
        int  pulses = 0;
        bit  prev_low = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (prev_low && bus.out_valid) pulses++;
            if (!bus.in_ready) low++;
            prev_low = !bus.in_ready;
            if (!prev_low && i > 0) break;
        end
        check("flush_ready_low_cycles", 80'(low), 80'(c_W + 1));
        check("flush_window_pulses", 80'(pulses), 80'(c_W + 1));
        check("flush_back_to_idle_ready", 80'(bus.in_ready), 80'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 80'(bus.out_valid), 80'(0));
        check({tag, "_in_ready"}, 80'(bus.in_ready), 80'(1));
        check({tag, "_out_xy"}, 80'({bus.out_x, bus.out_y}), 80'(0));
        check({tag, "_window"}, 80'({bus.a0, bus.a1, bus.a2, bus.a3, bus.a4,
                                     bus.a5, bus.a6, bus.a7, bus.pix}), 80'(0));
    endtask

    // Monitor: every out_valid must follow a beat and match the scoreboard head
    initial begin
        win_t got;
        win_t exp;
        forever begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = '{x: bus.out_x, y: bus.out_y, a0: bus.a0, a1: bus.a1, a2: bus.a2,
                        a3: bus.a3, a4: bus.a4, a5: bus.a5, a6: bus.a6, a7: bus.a7,
                        pix: bus.pix};
                n_chk++;
                if (!beat_last) begin
                    n_err++;
                    $display("FAIL valid_without_beat: out_valid=1 at x=%0d y=%0d, required 0",
                             got.x, got.y);
                end
                n_chk++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_window: got x=%0d y=%0d %h, none expected",
                             got.x, got.y, got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        n_err++;
                        $display("FAIL window: got x=%0d y=%0d %h, expected x=%0d y=%0d %h",
                                 got.x, got.y, got, exp.x, exp.y, exp);
                    end
                end
            end
            beat_last = (bus.in_valid & bus.in_ready) | ~bus.in_ready;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.sof      = 1'b0;
        bus.pixel_in = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Beat without sof in IDLE is dropped
        send(8'h55, 1'b0);
        idle(4);

        // Continuous frame and flush
        push_range(0, c_W * c_H - 1);
        send_frame(1'b0);
        flush_check();
        idle(3);
        check("frame_a_sb_empty", 80'(sb.size()), 80'(0));

        // Frame with random in_valid bubbles
        push_range(0, c_W * c_H - 1);
        send_frame(1'b1);
        idle(12);
        check("frame_b_sb_empty", 80'(sb.size()), 80'(0));

        // Abort: sof again after seven beats, then a full new frame
        push_range(0, 1);
        for (int i = 0; i < 7; i++) send(px(i), i == 0);
        push_range(0, c_W * c_H - 1);
        for (int i = 0; i < 5; i++) send(px(i), i == 0);
        @(negedge clk);
        check("abort_no_window_after_5_beats", 80'(bus.out_valid), 80'(0));
        @(posedge clk);
        #1;
        send(px(5), 1'b0);
        @(negedge clk);
        check("abort_first_window_latency", 80'(bus.out_valid), 80'(1));
        @(posedge clk);
        #1;
        for (int i = 6; i < c_W * c_H; i++) send(px(i), 1'b0);
        idle(12);
        check("abort_sb_empty", 80'(sb.size()), 80'(0));

        // Reset during flush: windows up to the first flush beat only
        push_range(0, 2 * c_W - 1);
        send_frame(1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("flush_rst");
        @(posedge clk);
        #1;
        idle(10);
        check("flush_rst_sb_empty", 80'(sb.size()), 80'(0));

        // Full frame after the reset
        push_range(0, c_W * c_H - 1);
        send_frame(1'b1);
        idle(12);
        check("final_sb_empty", 80'(sb.size()), 80'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
